fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the RISC-V core, sitting directly upstream of the main decoder: it owns the program counter, issues requests to instruction memory over a ready-qualified handshake, and drives the IF/ID register whose `instrD[6:0]` is the decoder's opcode input. It handles decode stalls with a one-entry skid buffer and redirects (branch/jal) by flushing to a NOP and discarding any in-flight response.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013: `addi x0,x0,0`, driven on `instrD` whenever the slot is invalid.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  XLEN  fetch address, equals internal PC.
- `imem_ready`  in  1  response valid; transfer occurs when `imem_req & imem_ready`.
- `imem_rdata`  in  XLEN  instruction word, valid with `imem_ready`.
- `stall`  in  1  decode cannot accept; hold IF/ID contents.
- `redirect`  in  1  taken branch or jump resolved this cycle.
- `redirect_pc`  in  XLEN  new fetch target, sampled with `redirect`.
- `instrD`  out  XLEN  instruction to decoder.
- `pcD`  out  XLEN  PC of `instrD`.
- `pcplus4D`  out  XLEN  `pcD + 4`, modulo 2^XLEN.
- `validD`  out  1  `instrD` is a real instruction.

## Operation
- States: FETCH (request outstanding), DROP (request outstanding, response must be discarded), SKID (one response buffered, no request).
- `imem_req` = 1 in FETCH and DROP, 0 in SKID and during reset; `imem_addr` stable while `imem_req=1` and not accepted.
- FETCH, transfer, `stall=0`, `redirect=0`: IF/ID <= {rdata, pc, pc+4, valid=1}; pc <= pc+4; stay FETCH.
- FETCH, transfer, `stall=1`: response into skid {rdata, pc}; pc <= pc+4; go SKID. IF/ID unchanged.
- FETCH, no transfer, `stall=0`: `validD` <= 0, `instrD` <= NOP_INSTR (bubble).
- SKID, `stall=0`: IF/ID <= skid, valid=1; go FETCH. SKID, `stall=1`: hold.
- `redirect=1` (any state, priority over stall): IF/ID <= NOP, valid=0; skid cleared; pc <= `redirect_pc`. If in FETCH/DROP with no transfer this cycle, go DROP (memory cannot cancel); else go FETCH.
- DROP, transfer: data discarded, go FETCH (pc already holds target). DROP, no transfer: stay.
- `stall` while `validD=0` is legal; contents held.
- PC arithmetic wraps at 2^XLEN; low two bits of `redirect_pc` passed through unchanged (alignment checked elsewhere).

## Timing
- Reset values: pc=RESET_PC, state FETCH, `validD`=0, `instrD`=NOP_INSTR, `pcD`=0, `pcplus4D`=4, skid empty; `imem_req`=0 in the reset cycle, 1 in the first cycle after.
- Zero-wait memory (`imem_ready` tied 1): `instrD` for RESET_PC valid one cycle after first request; one instruction per cycle sustained.
- Fetch-to-decode latency: one edge after transfer.
- Redirect penalty with zero-wait memory: one bubble; next valid `instrD` has `pcD=redirect_pc` two edges after redirect.
- Reset mid-operation (any state, outstanding request): all state to reset values next edge; late response ignored because `imem_req`=0.
- All outputs registered except `imem_req`/`imem_addr` (decoded from state and pc register).

## Structure
- Shared core package: `XLEN`, `NOP_INSTR`, `RESET_PC` defaults, state encoding typedef.
- Natural sub-module: `ifid_reg` (IF/ID register with enable and flush-to-NOP), reused by later pipeline registers.

## Test plan
- Reset, `imem_ready`=1, memory returns addr-as-data: `pcD` sequence 0,4,8,… with `validD`=1 from second cycle after reset release.
- `stall`=1 for 3 cycles at pcD=8: `instrD` holds word@8, one request transfers (@12) into skid, `imem_req`=0 next; release -> pcD=12 then 16, no loss or duplicate.
- `redirect`=1, `redirect_pc`=0x100 with ready=1: next `validD`=0, `instrD`=0x00000013, then pcD=0x100.
- Memory 3-cycle latency, redirect to 0x200 in first wait cycle: original response discarded, next request at 0x200, first valid `pcD`=0x200.
- Redirect and stall same cycle while SKID full: skid cleared, `validD`=0, resumes at `redirect_pc`.
- `redirect_pc`=0xFFFFFFFC: `pcplus4D`=0x00000000, next fetch address 0x00000000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage and the IF/ID register.
// Widths, reset defaults, fetch state encoding and the IF/ID bundle.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_SKID  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  function automatic if_id_t ifid_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.instr   = nop;
    b.pc      = '0;
    b.pcplus4 = XLEN'(4);
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load enable and flush-to-NOP.
// Reset and flush both load the bubble bundle.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      q_q <= ifid_bubble(NOP);
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, one-entry skid buffer,
// redirect with discard of a response the memory cannot cancel.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          skid_q, skid_d;

  logic            xfer;
  logic [XLEN-1:0] pc_plus4;
  if_id_t          fetched;
  if_id_t          ifid_d, ifid_q;
  logic            ifid_en, ifid_flush;

  assign imem_req  = ~reset & (state_q != S_SKID);
  assign imem_addr = pc_q;
  assign xfer      = imem_req & imem_ready;
  assign pc_plus4  = pc_q + XLEN'(4);

  always_comb begin
    fetched.instr   = imem_rdata;
    fetched.pc      = pc_q;
    fetched.pcplus4 = pc_plus4;
    fetched.valid   = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    ifid_d     = fetched;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    if (redirect) begin
      ifid_flush = 1'b1;
      skid_d     = '0;
      pc_d       = redirect_pc;
      // An accepted-but-unanswered request will still return; drop it.
      state_d    = (state_q != S_SKID && !xfer) ? S_DROP : S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (xfer) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_d  = fetched;
              state_d = S_SKID;
            end else begin
              ifid_en = 1'b1;
            end
          end else if (!stall) begin
            ifid_flush = 1'b1;
          end
        end
        S_SKID: begin
          if (!stall) begin
            ifid_d  = skid_q;
            ifid_en = 1'b1;
            skid_d  = '0;
            state_d = S_FETCH;
          end
        end
        S_DROP: begin
          if (xfer) state_d = S_FETCH;
          if (!stall) ifid_flush = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  ifid_reg #(
    .NOP(NOP_INSTR)
  ) u_ifid (
    .clk    (clk),
    .reset  (reset),
    .en_i   (ifid_en),
    .flush_i(ifid_flush),
    .d_i    (ifid_d),
    .q_o    (ifid_q)
  );

  assign instrD   = ifid_q.instr;
  assign pcD      = ifid_q.pc;
  assign pcplus4D = ifid_q.pcplus4;
  assign validD   = ifid_q.valid;

endmodule
